ysyx_l1_bus_arb: RTL and testbench
==================================

Name: ysyx_l1_bus_arb

Overview:
- Parametrised N-channel arbiter between L1 caches and the single downstream memory bus.
- Successor to the fixed one-I/one-D bus pairing: NRD read channels (L1I, L1D, prefetch, ...) plus one write channel share one port.
- Adds round-robin read grant, burst forwarding (rlast), optional write priority and per-channel abort with beat draining.
- Sits between the L1I/L1D bus masters and the core's external bus bridge.

Parameters:
- XLEN, 32, address/data width.
- NRD, 2, number of read channels (2..8).
- WR_PRIO, 1, 1 = pending write beats pending reads at IDLE; 0 = write joins the round robin as channel NRD.
- MAXBEAT, 8, burst-length watchdog; a burst exceeding this raises err.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- m_arvalid  in  NRD  per-channel read request; held until m_arready.
- m_araddr  in  NRD*XLEN  per-channel read address; channel i at [i*XLEN +: XLEN].
- m_rstrb  in  NRD*8  per-channel read byte strobe.
- m_arready  out  NRD  one-cycle pulse: request of channel i accepted downstream.
- m_rvalid  out  NRD  beat valid for channel i; at most one bit set.
- m_rdata  out  XLEN  shared beat data.
- m_rlast  out  1  last beat of the burst; qualified by m_rvalid.
- m_abort  in  NRD  channel i abandons its in-flight burst (pipe flush).
- w_awvalid  in  1  write request, held until w_wready.
- w_awaddr  in  XLEN  write address.
- w_wdata  in  XLEN  write data.
- w_wstrb  in  8  write byte strobe.
- w_wready  out  1  one-cycle pulse: write complete (downstream bvalid seen).
- s_arvalid  out  1  downstream read request.
- s_araddr  out  XLEN  downstream read address.
- s_rstrb  out  8  downstream read strobe.
- s_arready  in  1  downstream read request accepted.
- s_rvalid  in  1  downstream beat valid.
- s_rdata  in  XLEN  downstream beat data.
- s_rlast  in  1  downstream last beat.
- s_awvalid  out  1  downstream write address valid.
- s_awaddr  out  XLEN  downstream write address.
- s_wvalid  out  1  downstream write data valid.
- s_wdata  out  XLEN  downstream write data.
- s_wstrb  out  8  downstream write strobe.
- s_awready  in  1  downstream write address/data accepted.
- s_bvalid  in  1  downstream write response.
- busy  out  1  FSM not in IDLE.
- err  out  1  sticky; burst exceeded MAXBEAT. Cleared only by reset.

Behaviour:
- Reset: FSM=IDLE, round-robin pointer=0, every output 0, drop mask cleared, beat counter=0.
- FSM states and transitions:
  - IDLE: arbitrate, latch grant, address and strobe in registers.
  - RADDR: s_arvalid=1 with latched values until s_arready. In that cycle pulse m_arready[g] and go to RDATA.
  - RDATA: forward each s_rvalid beat as m_rvalid[g], m_rdata, m_rlast combinationally (zero-latency data path). On s_rvalid&s_rlast go to IDLE.
  - WADDR: s_awvalid=s_wvalid=1 until s_awready, then go to WRESP.
  - WRESP: on s_bvalid pulse w_wready and go to IDLE.
- Arbitration in IDLE:
  - Grant goes to the first requesting channel at or after the pointer, modulo NRD.
  - After a grant, pointer=g+1, wrapping NRD-1 to 0.
  - WR_PRIO=1: w_awvalid wins over reads. WR_PRIO=0: write is channel NRD in the rotation.
  - Grant to m_arready latency: minimum 2 cycles (IDLE, RADDR with s_arready=1).
  - A channel deasserting m_arvalid before its grant loses the request; no glitch on the s_ side.
- Abort:
  - m_abort[g] during RADDR or RDATA sets the drop flag.
  - The downstream burst is still drained to rlast; m_rvalid stays 0 for the remaining beats, including a beat arriving in the abort cycle.
  - In RADDR, s_arvalid is not withdrawn.
  - m_abort of a non-granted channel has no effect.
- Simultaneous events: s_rlast in RDATA with new requests pending → IDLE first, new grant next cycle; no back-to-back bypass.
- Watchdog: beat counter is clog2(MAXBEAT)+1 bits and saturates; at beat MAXBEAT+1 set err. Forwarding continues.
- Reset mid-burst returns to IDLE. The downstream bridge is reset by the same signal.
- Invariant: $onehot0(m_rvalid).

Decomposition:
- Shared package ysyx_pkg:
  - arb_state_t enum: IDLE, RADDR, RDATA, WADDR, WRESP.
  - constant YSYX_BUS_STRB_W=8.
- Sub-module ysyx_rr_arb (NRD_P, req, ptr → onehot grant, index), combinational, reusable for other arbiters.
- The FSM and registers stay in ysyx_l1_bus_arb.

Test Plan:
- Channel 0 requests 0x8000_0000, 4-beat burst → m_arready[0] pulses 2 cycles after request with s_arready tied 1. Four m_rvalid[0] beats carry data 0..3, m_rlast on beat 4, busy falls next cycle.
- Channels 0 and 1 request continuously, NRD=2 → grants alternate 0,1,0,1. Pointer wraps; no channel starves over 8 bursts.
- Write 0x1000 with data 0xDEAD_BEEF, wstrb=0x0F, plus a concurrent read, WR_PRIO=1 → write issued first. w_wready pulses on s_bvalid, then the read is granted.
- m_abort[1] asserted after beat 1 of a 4-beat burst → s-side beats 2..4 consumed, m_rvalid[1] stays 0, FSM returns to IDLE after s_rlast.
- 10-beat downstream burst with MAXBEAT=8 → err rises on beat 9 and stays set. Reset asserted mid-RDATA → all outputs 0 next cycle, err cleared.

Source files
------------

// File: rtl/ysyx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_pkg
// Description : Shared types and constants for the L1 bus arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_pkg;

    localparam int YSYX_BUS_STRB_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RADDR = 3'd1,
        RDATA = 3'd2,
        WADDR = 3'd3,
        WRESP = 3'd4
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/ysyx_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_rr_arb
// Description : Combinational round-robin picker: first request at or after
//               ptr (mod NRD_P), returned as one-hot grant plus index.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_rr_arb
    import ysyx_pkg::*;
#(
    parameter int NRD_P = 2,
    parameter int PTR_W = 1
) (
    input  logic [NRD_P-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NRD_P-1:0] grant,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    int w_cand;

    always_comb begin
        grant  = '0;
        idx    = '0;
        any    = 1'b0;
        w_cand = 0;
        for (int off = 0; off < NRD_P; off++) begin
            w_cand = int'(ptr) + off;
            if (w_cand >= NRD_P) begin
                w_cand = w_cand - NRD_P;
            end
            // Constant-indexed scan keeps the select free of variable indexing.
            for (int i = 0; i < NRD_P; i++) begin
                if (!any && req[i] && (i == w_cand)) begin
                    any      = 1'b1;
                    grant[i] = 1'b1;
                    idx      = PTR_W'(i);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_l1_bus_arb.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_l1_bus_arb
// Description : N read channels plus one write channel arbitrated onto a
//               single downstream bus, with burst forwarding and abort drain.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_l1_bus_arb
    import ysyx_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NRD     = 2,
    parameter int WR_PRIO = 1,
    parameter int MAXBEAT = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NRD-1:0]                 m_arvalid,
    input  logic [NRD*XLEN-1:0]            m_araddr,
    input  logic [NRD*YSYX_BUS_STRB_W-1:0] m_rstrb,
    output logic [NRD-1:0]                 m_arready,
    output logic [NRD-1:0]                 m_rvalid,
    output logic [XLEN-1:0]                m_rdata,
    output logic                           m_rlast,
    input  logic [NRD-1:0]                 m_abort,
    input  logic                           w_awvalid,
    input  logic [XLEN-1:0]                w_awaddr,
    input  logic [XLEN-1:0]                w_wdata,
    input  logic [YSYX_BUS_STRB_W-1:0]     w_wstrb,
    output logic                           w_wready,
    output logic                           s_arvalid,
    output logic [XLEN-1:0]                s_araddr,
    output logic [YSYX_BUS_STRB_W-1:0]     s_rstrb,
    input  logic                           s_arready,
    input  logic                           s_rvalid,
    input  logic [XLEN-1:0]                s_rdata,
    input  logic                           s_rlast,
    output logic                           s_awvalid,
    output logic [XLEN-1:0]                s_awaddr,
    output logic                           s_wvalid,
    output logic [XLEN-1:0]                s_wdata,
    output logic [YSYX_BUS_STRB_W-1:0]     s_wstrb,
    input  logic                           s_awready,
    input  logic                           s_bvalid,
    output logic                           busy,
    output logic                           err
);

    localparam int c_nch    = (WR_PRIO != 0) ? NRD : NRD + 1;
    localparam int c_ptr_w  = $clog2(c_nch);
    localparam int c_beat_w = $clog2(MAXBEAT) + 1;

    localparam logic [c_ptr_w-1:0]  c_ptr_last = c_ptr_w'(c_nch - 1);
    localparam logic [c_beat_w-1:0] c_maxbeat  = c_beat_w'(MAXBEAT);
    localparam logic [c_beat_w-1:0] c_beat_sat = '1;

    arb_state_t                 r_state;
    arb_state_t                 w_state_n;
    logic [c_ptr_w-1:0]         r_ptr;
    logic [NRD-1:0]             r_gnt;
    logic [XLEN-1:0]            r_addr;
    logic [XLEN-1:0]            r_wdata;
    logic [YSYX_BUS_STRB_W-1:0] r_strb;
    logic                       r_drop;
    logic [c_beat_w-1:0]        r_beat;
    logic                       r_err;

    logic [c_ptr_w-1:0]         w_arb_idx;
    logic [NRD-1:0]             w_rd_gnt;
    logic                       w_wr_go;
    logic                       w_rd_go;
    logic                       w_ptr_adv;
    logic [XLEN-1:0]            w_sel_addr;
    logic [YSYX_BUS_STRB_W-1:0] w_sel_strb;
    logic                       w_abort_hit;
    logic                       w_fwd;

    // Write either pre-empts the read arbiter or takes slot NRD of the rotation.
    if (WR_PRIO != 0) begin : g_wr_prio
        logic [NRD-1:0] w_gnt;
        logic           w_any;

        ysyx_rr_arb #(
            .NRD_P (NRD),
            .PTR_W (c_ptr_w)
        ) u_rr_arb (
            .req   (m_arvalid),
            .ptr   (r_ptr),
            .grant (w_gnt),
            .idx   (w_arb_idx),
            .any   (w_any)
        );

        assign w_wr_go   = w_awvalid;
        assign w_rd_go   = !w_awvalid && w_any;
        assign w_rd_gnt  = w_gnt;
        assign w_ptr_adv = w_rd_go;
    end else begin : g_wr_rr
        logic [NRD:0] w_gnt;
        logic         w_any;

        ysyx_rr_arb #(
            .NRD_P (NRD + 1),
            .PTR_W (c_ptr_w)
        ) u_rr_arb (
            .req   ({w_awvalid, m_arvalid}),
            .ptr   (r_ptr),
            .grant (w_gnt),
            .idx   (w_arb_idx),
            .any   (w_any)
        );

        assign w_wr_go   = w_any && w_gnt[NRD];
        assign w_rd_go   = w_any && !w_gnt[NRD];
        assign w_rd_gnt  = w_gnt[NRD-1:0];
        assign w_ptr_adv = w_any;
    end

    always_comb begin
        w_sel_addr = '0;
        w_sel_strb = '0;
        for (int i = 0; i < NRD; i++) begin
            if (w_rd_gnt[i]) begin
                w_sel_addr = m_araddr[i*XLEN +: XLEN];
                w_sel_strb = m_rstrb[i*YSYX_BUS_STRB_W +: YSYX_BUS_STRB_W];
            end
        end
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            IDLE: begin
                if (w_wr_go) begin
                    w_state_n = WADDR;
                end else if (w_rd_go) begin
                    w_state_n = RADDR;
                end
            end
            RADDR:   if (s_arready)           w_state_n = RDATA;
            RDATA:   if (s_rvalid && s_rlast) w_state_n = IDLE;
            WADDR:   if (s_awready)           w_state_n = WRESP;
            WRESP:   if (s_bvalid)            w_state_n = IDLE;
            default:                          w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // An abort in the current cycle already suppresses that cycle's beat.
    assign w_abort_hit = |(m_abort & r_gnt);
    assign w_fwd       = (r_state == RDATA) && s_rvalid && !r_drop && !w_abort_hit;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_strb  <= '0;
            r_drop  <= 1'b0;
            r_beat  <= '0;
            r_err   <= 1'b0;
        end else begin
            if (r_state == IDLE) begin
                if (w_wr_go) begin
                    r_gnt   <= '0;
                    r_addr  <= w_awaddr;
                    r_wdata <= w_wdata;
                    r_strb  <= w_wstrb;
                end else if (w_rd_go) begin
                    r_gnt  <= w_rd_gnt;
                    r_addr <= w_sel_addr;
                    r_strb <= w_sel_strb;
                    r_drop <= 1'b0;
                    r_beat <= '0;
                end
                if (w_ptr_adv) begin
                    r_ptr <= (w_arb_idx == c_ptr_last) ? '0 : w_arb_idx + 1'b1;
                end
            end
            if (((r_state == RADDR) || (r_state == RDATA)) && w_abort_hit) begin
                r_drop <= 1'b1;
            end
            if ((r_state == RDATA) && s_rvalid) begin
                if (r_beat != c_beat_sat) begin
                    r_beat <= r_beat + 1'b1;
                end
                if (r_beat >= c_maxbeat) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign m_arready = r_gnt & {NRD{(r_state == RADDR) && s_arready && !r_drop && !w_abort_hit}};
    assign m_rvalid  = r_gnt & {NRD{w_fwd}};
    assign m_rdata   = w_fwd ? s_rdata : '0;
    assign m_rlast   = w_fwd && s_rlast;

    assign s_arvalid = (r_state == RADDR);
    assign s_araddr  = r_addr;
    assign s_rstrb   = r_strb;
    assign s_awvalid = (r_state == WADDR);
    assign s_wvalid  = (r_state == WADDR);
    assign s_awaddr  = r_addr;
    assign s_wdata   = r_wdata;
    assign s_wstrb   = r_strb;
    assign w_wready  = (r_state == WRESP) && s_bvalid;

    assign busy = (r_state != IDLE);
    assign err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_l1_bus_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_l1_bus_arb
// Description : Directed self-checking bench for ysyx_l1_bus_arb (NRD=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_l1_bus_arb;

    localparam int XLEN = 32;
    localparam int NRD  = 2;

    logic            clock;
    logic            reset;
    logic [NRD-1:0]  m_arvalid;
    logic [NRD*XLEN-1:0] m_araddr;
    logic [NRD*8-1:0] m_rstrb;
    logic [NRD-1:0]  m_arready;
    logic [NRD-1:0]  m_rvalid;
    logic [XLEN-1:0] m_rdata;
    logic            m_rlast;
    logic [NRD-1:0]  m_abort;
    logic            w_awvalid;
    logic [XLEN-1:0] w_awaddr;
    logic [XLEN-1:0] w_wdata;
    logic [7:0]      w_wstrb;
    logic            w_wready;
    logic            s_arvalid;
    logic [XLEN-1:0] s_araddr;
    logic [7:0]      s_rstrb;
    logic            s_arready;
    logic            s_rvalid;
    logic [XLEN-1:0] s_rdata;
    logic            s_rlast;
    logic            s_awvalid;
    logic [XLEN-1:0] s_awaddr;
    logic            s_wvalid;
    logic [XLEN-1:0] s_wdata;
    logic [7:0]      s_wstrb;
    logic            s_awready;
    logic            s_bvalid;
    logic            busy;
    logic            err;

    int n_assert = 0;
    int n_fail   = 0;

    ysyx_l1_bus_arb #(
        .XLEN    (XLEN),
        .NRD     (NRD),
        .WR_PRIO (1),
        .MAXBEAT (8)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .m_arvalid (m_arvalid),
        .m_araddr  (m_araddr),
        .m_rstrb   (m_rstrb),
        .m_arready (m_arready),
        .m_rvalid  (m_rvalid),
        .m_rdata   (m_rdata),
        .m_rlast   (m_rlast),
        .m_abort   (m_abort),
        .w_awvalid (w_awvalid),
        .w_awaddr  (w_awaddr),
        .w_wdata   (w_wdata),
        .w_wstrb   (w_wstrb),
        .w_wready  (w_wready),
        .s_arvalid (s_arvalid),
        .s_araddr  (s_araddr),
        .s_rstrb   (s_rstrb),
        .s_arready (s_arready),
        .s_rvalid  (s_rvalid),
        .s_rdata   (s_rdata),
        .s_rlast   (s_rlast),
        .s_awvalid (s_awvalid),
        .s_awaddr  (s_awaddr),
        .s_wvalid  (s_wvalid),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_awready (s_awready),
        .s_bvalid  (s_bvalid),
        .busy      (busy),
        .err       (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic ok);
        n_assert++;
        if (ok !== 1'b1) begin
            n_fail++;
            $error("FAIL %s", tag);
        end
    endtask

    // Starts in an IDLE cycle just after a clock edge, ends likewise.
    task automatic burst(input logic [1:0] req, input int exp_ch, input logic [31:0] exp_addr,
                         input logic [7:0] exp_strb, input int nb);
        m_arvalid = req;
        #1;
        chk("idle_busy", busy === 1'b0);
        tick();
        #1;
        chk("raddr_arvalid", s_arvalid === 1'b1);
        chk("raddr_addr", s_araddr === exp_addr);
        chk("raddr_strb", s_rstrb === exp_strb);
        chk("raddr_arready", m_arready === 2'(1 << exp_ch));
        for (int b = 0; b < nb; b++) begin
            tick();
            s_rvalid = 1'b1;
            s_rdata  = 32'(256 * exp_ch + b);
            s_rlast  = (b == nb - 1);
            #1;
            chk("beat_rvalid", m_rvalid === 2'(1 << exp_ch));
            chk("beat_rdata", m_rdata === 32'(256 * exp_ch + b));
            chk("beat_rlast", m_rlast === (b == nb - 1));
        end
        tick();
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        m_arvalid = '0;
        m_araddr  = {32'h4000_0100, 32'h8000_0000};
        m_rstrb   = {8'h0F, 8'hFF};
        m_abort   = '0;
        w_awvalid = 1'b0;
        w_awaddr  = '0;
        w_wdata   = '0;
        w_wstrb   = '0;
        s_arready = 1'b1;
        s_rvalid  = 1'b0;
        s_rdata   = '0;
        s_rlast   = 1'b0;
        s_awready = 1'b0;
        s_bvalid  = 1'b0;

        // Reset state
        tick();
        tick();
        #1;
        chk("rst_busy", busy === 1'b0);
        chk("rst_err", err === 1'b0);
        chk("rst_arvalid", s_arvalid === 1'b0);
        chk("rst_awvalid", s_awvalid === 1'b0);
        chk("rst_araddr", s_araddr === 32'h0);
        chk("rst_arready", m_arready === 2'b00);
        chk("rst_rvalid", m_rvalid === 2'b00);
        reset = 1'b0;
        tick();

        // Single 4-beat burst on channel 0
        burst(2'b01, 0, 32'h8000_0000, 8'hFF, 4);

        // Both channels requesting: pointer is 1 after the channel-0 grant
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) burst(2'b11, 1, 32'h4000_0100, 8'h0F, 2);
            else            burst(2'b11, 0, 32'h8000_0000, 8'hFF, 2);
        end

        // Write with a concurrent read: write goes first
        m_arvalid = 2'b01;
        w_awvalid = 1'b1;
        w_awaddr  = 32'h0000_1000;
        w_wdata   = 32'hDEAD_BEEF;
        w_wstrb   = 8'h0F;
        tick();
        #1;
        chk("wr_awvalid", s_awvalid === 1'b1);
        chk("wr_wvalid", s_wvalid === 1'b1);
        chk("wr_awaddr", s_awaddr === 32'h0000_1000);
        chk("wr_wdata", s_wdata === 32'hDEAD_BEEF);
        chk("wr_wstrb", s_wstrb === 8'h0F);
        chk("wr_no_read", s_arvalid === 1'b0);
        s_awready = 1'b1;
        tick();
        s_awready = 1'b0;
        #1;
        chk("wresp_awvalid", s_awvalid === 1'b0);
        chk("wresp_wready_wait", w_wready === 1'b0);
        s_bvalid = 1'b1;
        #1;
        chk("wresp_wready", w_wready === 1'b1);
        tick();
        s_bvalid  = 1'b0;
        w_awvalid = 1'b0;
        #1;
        chk("wr_done_wready", w_wready === 1'b0);
        burst(2'b01, 0, 32'h8000_0000, 8'hFF, 1);

        // Abort on channel 1 after its first beat
        m_arvalid = 2'b10;
        tick();
        #1;
        chk("ab_arready", m_arready === 2'b10);
        tick();
        m_arvalid = 2'b00;
        m_abort   = 2'b01;
        s_rvalid  = 1'b1;
        s_rdata   = 32'hA0;
        #1;
        chk("ab_other_abort_ignored", m_rvalid === 2'b10);
        tick();
        m_abort = 2'b10;
        s_rdata = 32'hA1;
        #1;
        chk("ab_same_cycle_beat", m_rvalid === 2'b00);
        tick();
        m_abort = 2'b00;
        s_rdata = 32'hA2;
        #1;
        chk("ab_drain_beat", m_rvalid === 2'b00);
        chk("ab_drain_busy", busy === 1'b1);
        tick();
        s_rdata = 32'hA3;
        s_rlast = 1'b1;
        #1;
        chk("ab_last_rvalid", m_rvalid === 2'b00);
        chk("ab_last_rlast", m_rlast === 1'b0);
        tick();
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        #1;
        chk("ab_idle", busy === 1'b0);

        // 10-beat burst against MAXBEAT=8
        m_arvalid = 2'b01;
        tick();
        tick();
        m_arvalid = 2'b00;
        for (int b = 0; b < 10; b++) begin
            s_rvalid = 1'b1;
            s_rdata  = 32'(b);
            s_rlast  = (b == 9);
            #1;
            chk("wd_rvalid", m_rvalid === 2'b01);
            chk("wd_err", err === (b == 9));
            tick();
        end
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        #1;
        chk("wd_err_sticky", err === 1'b1);
        chk("wd_idle", busy === 1'b0);

        // Reset in the middle of a burst
        m_arvalid = 2'b01;
        tick();
        tick();
        m_arvalid = 2'b00;
        s_rvalid  = 1'b1;
        s_rdata   = 32'h55;
        #1;
        chk("mid_rvalid", m_rvalid === 2'b01);
        reset = 1'b1;
        tick();
        #1;
        chk("mid_rst_busy", busy === 1'b0);
        chk("mid_rst_err", err === 1'b0);
        chk("mid_rst_rvalid", m_rvalid === 2'b00);
        chk("mid_rst_rdata", m_rdata === 32'h0);
        chk("mid_rst_araddr", s_araddr === 32'h0);
        reset    = 1'b0;
        s_rvalid = 1'b0;
        tick();
        // Pointer back at 0 after reset
        burst(2'b11, 0, 32'h8000_0000, 8'hFF, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
